// File: rtl/el_pkg.sv
// Shared types and helpers for the elastic-channel arbiter family.
package el_pkg;

  typedef enum logic [1:0] {IDLE, DATA, NULL, HALT} state_e;

  localparam int SYNC_STAGES = 2;

  // One-hot rail code for a symbol. An out-of-range symbol maps to symbol 0.
  function automatic logic [31:0] onehot(input int unsigned sym, input int unsigned rail_num);
    logic [31:0] r;
    r = 32'd1;
    if (sym < rail_num) r = 32'd1 << sym;
    return r;
  endfunction

endpackage

// File: rtl/el_ack_sync.sv
// Flop-chain synchronizer bringing an asynchronous elastic ack into the clock domain.
module el_ack_sync
  import el_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/el_ch_arb.sv
// Round-robin arbiter granting one four-phase 1-of-N elastic channel to N_REQ requesters.
module el_ch_arb
  import el_pkg::*;
#(
  parameter int RAIL_NUM = 2,
  parameter int N_REQ    = 4,
  parameter int SYM_W    = (RAIL_NUM > 1) ? $clog2(RAIL_NUM) : 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*SYM_W-1:0] sym_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [RAIL_NUM-1:0]    ch_o,
  input  logic                   ack_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = $clog2(N_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RAIL_NUM-1:0] ch_q, ch_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                ack_s;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [SYM_W-1:0]    pick_sym;
  logic [31:0]         pick_oh;
  logic                cnt_to;
  logic [CNT_W-1:0]    cnt_inc;
  logic [IDX_W-1:0]    ptr_nxt;

  el_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_i),
    .q_o (ack_s)
  );

  // Search upward from ptr with wrap; first set request wins.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr_q) + i) % N_REQ;
      if (!pick_vld && req_i[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  assign pick_sym = sym_i[int'(pick_idx)*SYM_W +: SYM_W];
  assign pick_oh  = onehot(32'(pick_sym), RAIL_NUM);
  assign cnt_to   = (cnt_q == CNT_W'(TIMEOUT));
  assign cnt_inc  = cnt_to ? cnt_q : cnt_q + CNT_W'(1);
  assign ptr_nxt  = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    err_d   = err_q;
    gnt_d   = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          ch_d    = pick_oh[RAIL_NUM-1:0];
          gnt_d   = N_REQ'(1) << pick_idx;
          win_d   = pick_idx;
          cnt_d   = '0;
          state_d = DATA;
          if (32'(pick_sym) >= RAIL_NUM) err_d = 1'b1;
        end
      end
      DATA: begin
        if (ack_s) begin
          ch_d    = '0;
          cnt_d   = '0;
          state_d = NULL;
        end else if (cnt_to) begin
          // Stuck data phase: force null and still finish the handshake.
          ch_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = NULL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      NULL: begin
        if (!ack_s) begin
          done_d  = N_REQ'(1) << win_q;
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end else if (cnt_to) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ch_o   = ch_q;
  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule
